// File: rtl/floo_wide_link_serializer_pkg.sv
// Shared types and helpers for the wide-link serializer and its far-end deserializer.
//   floo_wide_chan_t : wide flit type; its width sizes the serializer's default FlitWidth
//   ser_state_e      : serializer FSM states (IDLE: no flit held, SEND: emitting beats)
//   floo_num_beats   : phits needed to carry one flit (ceiling division)
//   floo_cnt_width   : beat counter width, at least one bit
package floo_wide_link_serializer_pkg;

   localparam int unsigned WideFlitWidth = 512;

   typedef logic [WideFlitWidth-1:0] floo_wide_chan_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

   function automatic int unsigned floo_num_beats(input int unsigned flit_w,
                                                  input int unsigned phit_w);
      return (flit_w + phit_w - 1) / phit_w;
   endfunction

   function automatic int unsigned floo_cnt_width(input int unsigned num_beats);
      return (num_beats > 1) ? $clog2(num_beats) : 1;
   endfunction

endpackage

// File: rtl/floo_wide_link_serializer_if.sv
// Router-to-link handshake bundle for the wide-link serializer.
//   valid_i/ready_o/data_i                   : wide flit from the router output port
//   phit_valid_o/phit_ready_i/phit_data_o    : narrow phits toward the physical link
//   phit_last_o                              : final beat of a flit
//   phit_parity_o                            : even parity of phit_data_o (0 unless FLOO_LINK_PARITY_EN)
// Modports: slave = serializer view, master = router/link-side driver view.
// FlitWidth/PhitWidth must match the parameters of the serializer bound to it.
interface floo_wide_link_serializer_if
   import floo_wide_link_serializer_pkg::*;
#(
   parameter int unsigned FlitWidth = $bits(floo_wide_chan_t),
   parameter int unsigned PhitWidth = 128
) ();

   logic                 valid_i;
   logic                 ready_o;
   logic [FlitWidth-1:0] data_i;
   logic                 phit_valid_o;
   logic                 phit_ready_i;
   logic [PhitWidth-1:0] phit_data_o;
   logic                 phit_last_o;
   logic                 phit_parity_o;

   modport slave (
      input  valid_i, data_i, phit_ready_i,
      output ready_o, phit_valid_o, phit_data_o, phit_last_o, phit_parity_o
   );

   modport master (
      output valid_i, data_i, phit_ready_i,
      input  ready_o, phit_valid_o, phit_data_o, phit_last_o, phit_parity_o
   );

endinterface

// File: rtl/floo_wide_link_serializer.sv
// Wide-link serializer: accepts one wide flit per handshake and emits it as
// NumBeats phits of PhitWidth bits, beat k = flit[k*PhitWidth +: PhitWidth],
// zero-padded above FlitWidth. Full throughput on back-to-back flits: the next
// flit is accepted in the same cycle the last beat of the current one leaves.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset; holds ready_o and phit_valid_o low
//   link   : floo_wide_link_serializer_if.slave (flit in, phit out)
// Build option:
//   FLOO_LINK_PARITY_EN : phit_parity_o = ^phit_data_o, registered with the beat;
//                         undefined ties phit_parity_o to 0.
module floo_wide_link_serializer
   import floo_wide_link_serializer_pkg::*;
#(
   parameter int unsigned FlitWidth = $bits(floo_wide_chan_t),
   parameter int unsigned PhitWidth = 128
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   floo_wide_link_serializer_if.slave    link
);

   localparam int unsigned NumBeats = floo_num_beats(FlitWidth, PhitWidth);
   localparam int unsigned CntWidth = floo_cnt_width(NumBeats);
   localparam int unsigned PadWidth = NumBeats * PhitWidth;
   localparam logic [CntWidth-1:0] LastBeat = CntWidth'(NumBeats - 1);

   ser_state_e           state_q;
   logic [CntWidth-1:0]  beat_q;
   logic [FlitWidth-1:0] flit_q;
   logic                 last;
   logic                 load;

   function automatic logic [PhitWidth-1:0] beat_slice(input logic [FlitWidth-1:0] flit,
                                                       input logic [CntWidth-1:0]  beat);
      logic [PadWidth-1:0]  pad;
      logic [PhitWidth-1:0] res;
      pad = PadWidth'(flit);
      res = '0;
      for (int unsigned k = 0; k < NumBeats; k++) begin
         if (beat == CntWidth'(k)) res = pad[k*PhitWidth +: PhitWidth];
      end
      return res;
   endfunction

   assign last = (state_q == SEND) && (beat_q == LastBeat);

   // The only path from link backpressure to the router: a new flit is taken
   // while idle, or exactly when the final beat is being accepted.
   assign link.ready_o      = !rst_i && ((state_q == IDLE) || (link.phit_ready_i && last));
   assign load              = link.valid_i && link.ready_o;
   assign link.phit_valid_o = !rst_i && (state_q == SEND);
   assign link.phit_data_o  = (state_q == SEND) ? beat_slice(flit_q, beat_q) : '0;
   assign link.phit_last_o  = last;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         beat_q  <= '0;
         flit_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load) begin
                  flit_q  <= link.data_i;
                  beat_q  <= '0;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (link.phit_ready_i) begin
                  if (!last) begin
                     beat_q <= beat_q + 1'b1;
                  end else if (load) begin
                     flit_q <= link.data_i;
                     beat_q <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef FLOO_LINK_PARITY_EN
   logic parity_q;

   // Parity of the beat that will be on phit_data_o next cycle, so it lines up
   // with the data instead of being a combinational XOR tree on the output.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         parity_q <= 1'b0;
      end else if (load) begin
         parity_q <= ^beat_slice(link.data_i, '0);
      end else if ((state_q == SEND) && link.phit_ready_i) begin
         parity_q <= last ? 1'b0 : ^beat_slice(flit_q, beat_q + 1'b1);
      end
   end

   assign link.phit_parity_o = parity_q & link.phit_valid_o;
`else
   assign link.phit_parity_o = 1'b0;
`endif

   a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (link.phit_valid_o && !link.phit_ready_i) |=>
      (link.phit_valid_o && $stable(link.phit_data_o) && $stable(link.phit_last_o)));

   a_beat_range: assert property (@(posedge clk_i) disable iff (rst_i)
      32'(beat_q) < NumBeats);

endmodule

// File: tb/tb_floo_wide_link_serializer.sv
module tb_floo_wide_link_serializer;

   typedef struct packed {
      logic [127:0] d;
      logic         last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   int   hs_log[$];

   // A: 512/128 (4 beats), B: 520/128 (5 beats, padded), C: 64/128 (1 beat)
   floo_wide_link_serializer_if #(.FlitWidth(512), .PhitWidth(128)) ifa ();
   floo_wide_link_serializer_if #(.FlitWidth(520), .PhitWidth(128)) ifb ();
   floo_wide_link_serializer_if #(.FlitWidth(64),  .PhitWidth(128)) ifc ();

   floo_wide_link_serializer #(.FlitWidth(512), .PhitWidth(128)) dut_a (
      .clk_i(clk), .rst_i(rst_i), .link(ifa.slave));
   floo_wide_link_serializer #(.FlitWidth(520), .PhitWidth(128)) dut_b (
      .clk_i(clk), .rst_i(rst_i), .link(ifb.slave));
   floo_wide_link_serializer #(.FlitWidth(64), .PhitWidth(128)) dut_c (
      .clk_i(clk), .rst_i(rst_i), .link(ifc.slave));

   // Link-side ready for A: constant 1, or the 1,0,0,1 stall pattern.
   logic       bp_en = 1'b0;
   logic [3:0] bp_pat = 4'b1001;
   int         bp_idx = 0;
   logic       link_rdy = 1'b1;
   always @(posedge clk) begin
      #1;
      if (bp_en) begin
         link_rdy = bp_pat[bp_idx];
         bp_idx   = (bp_idx + 1) % 4;
      end else begin
         link_rdy = 1'b1;
      end
   end
   assign ifa.phit_ready_i = link_rdy;
   assign ifb.phit_ready_i = 1'b1;
   assign ifc.phit_ready_i = 1'b1;

   function automatic logic exp_par(input logic [127:0] d);
`ifdef FLOO_LINK_PARITY_EN
      return ^d;
`else
      return (d === 128'hx) ? 1'b1 : 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   // ---------------- monitors ----------------
   exp_t         ea, eb, ec;
   logic         a_stalled = 1'b0;
   logic [127:0] a_held_d;
   logic         a_held_last;

   always @(negedge clk) begin
      if (!rst_i) begin
         if (a_stalled) begin
            chk1("a_stall_valid", ifa.phit_valid_o, 1'b1);
            chk("a_stall_data", ifa.phit_data_o, a_held_d);
            chk1("a_stall_last", ifa.phit_last_o, a_held_last);
         end
         if (ifa.phit_valid_o && ifa.phit_ready_i) begin
            a_stalled = 1'b0;
            if (qa.size() == 0) begin
               total++; bad++;
               $display("FAIL a_unexpected_phit got=%h exp=none", ifa.phit_data_o);
            end else begin
               ea = qa.pop_front();
               chk("a_data", ifa.phit_data_o, ea.d);
               chk1("a_last", ifa.phit_last_o, ea.last);
               chk1("a_parity", ifa.phit_parity_o, exp_par(ea.d));
               chk1("a_ready_on_last", ifa.ready_o, ea.last);
               hs_log.push_back(cyc);
            end
         end else if (ifa.phit_valid_o) begin
            a_stalled   = 1'b1;
            a_held_d    = ifa.phit_data_o;
            a_held_last = ifa.phit_last_o;
            chk1("a_ready_stalled", ifa.ready_o, 1'b0);
         end else begin
            a_stalled = 1'b0;
         end
      end else begin
         a_stalled = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst_i && ifb.phit_valid_o) begin
         if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected_phit got=%h exp=none", ifb.phit_data_o);
         end else begin
            eb = qb.pop_front();
            chk("b_data", ifb.phit_data_o, eb.d);
            chk1("b_last", ifb.phit_last_o, eb.last);
            chk1("b_parity", ifb.phit_parity_o, exp_par(eb.d));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_i && ifc.phit_valid_o) begin
         if (qc.size() == 0) begin
            total++; bad++;
            $display("FAIL c_unexpected_phit got=%h exp=none", ifc.phit_data_o);
         end else begin
            ec = qc.pop_front();
            chk("c_data", ifc.phit_data_o, ec.d);
            chk1("c_last", ifc.phit_last_o, ec.last);
            chk1("c_parity", ifc.phit_parity_o, exp_par(ec.d));
            chk1("c_ready", ifc.ready_o, 1'b1);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send_a(input logic [127:0] b0, input logic [127:0] b1,
                         input logic [127:0] b2, input logic [127:0] b3);
      logic got;
      qa.push_back('{d: b0, last: 1'b0});
      qa.push_back('{d: b1, last: 1'b0});
      qa.push_back('{d: b2, last: 1'b0});
      qa.push_back('{d: b3, last: 1'b1});
      ifa.data_i  = {b3, b2, b1, b0};
      ifa.valid_i = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = ifa.ready_o;
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL a_accept_timeout got=0 exp=1");
      end
      @(posedge clk);
      #1;
      ifa.valid_i = 1'b0;
      ifa.data_i  = '0;
   endtask

   task automatic send_b(input logic [7:0] top, input logic [127:0] b0, input logic [127:0] b1,
                         input logic [127:0] b2, input logic [127:0] b3,
                         input logic [127:0] exp4);
      logic got;
      qb.push_back('{d: b0, last: 1'b0});
      qb.push_back('{d: b1, last: 1'b0});
      qb.push_back('{d: b2, last: 1'b0});
      qb.push_back('{d: b3, last: 1'b0});
      qb.push_back('{d: exp4, last: 1'b1});
      ifb.data_i  = {top, b3, b2, b1, b0};
      ifb.valid_i = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = ifb.ready_o;
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL b_accept_timeout got=0 exp=1");
      end
      @(posedge clk);
      #1;
      ifb.valid_i = 1'b0;
      ifb.data_i  = '0;
   endtask

   task automatic send_c(input logic [63:0] f, input logic [127:0] exp0);
      logic got;
      qc.push_back('{d: exp0, last: 1'b1});
      ifc.data_i  = f;
      ifc.valid_i = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = ifc.ready_o;
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL c_accept_timeout got=0 exp=1");
      end
      @(posedge clk);
      #1;
      ifc.valid_i = 1'b0;
      ifc.data_i  = '0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && (qa.size() + qb.size() + qc.size()) != 0; i++) @(negedge clk);
      if ((qa.size() + qb.size() + qc.size()) != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout got=%0d exp=0", qa.size() + qb.size() + qc.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      ifa.valid_i = 1'b1;
      ifa.data_i  = {4{128'hDEAD}};
      ifb.valid_i = 1'b0;
      ifb.data_i  = '0;
      ifc.valid_i = 1'b0;
      ifc.data_i  = '0;

      // Reset held 3 cycles with a flit offered
      repeat (3) begin
         @(negedge clk);
         chk1("rst_ready", ifa.ready_o, 1'b0);
         chk1("rst_phit_valid", ifa.phit_valid_o, 1'b0);
      end
      rst_i       = 1'b0;
      ifa.valid_i = 1'b0;
      ifa.data_i  = '0;
      @(negedge clk);
      chk1("post_rst_ready", ifa.ready_o, 1'b1);
      chk1("post_rst_phit_valid", ifa.phit_valid_o, 1'b0);
      chk("post_rst_phit_data", ifa.phit_data_o, 128'h0);
      chk1("post_rst_phit_last", ifa.phit_last_o, 1'b0);
      chk1("post_rst_parity", ifa.phit_parity_o, 1'b0);

      // Single flit, beats 0,1,2,3; first phit the cycle after acceptance
      @(posedge clk);
      #1;
      send_a(128'h0, 128'h1, 128'h2, 128'h3);
      @(negedge clk);
      chk1("latency1_valid", ifa.phit_valid_o, 1'b1);
      chk("latency1_data", ifa.phit_data_o, 128'h0);
      wait_drain();
      @(negedge clk);
      chk1("idle_after_flit", ifa.phit_valid_o, 1'b0);

      // Three back-to-back flits: 12 phits on consecutive cycles
      hs_log.delete();
      @(posedge clk);
      #1;
      send_a(128'h1, 128'h3, 128'h7, 128'hF);
      send_a(128'h10, 128'h11, 128'h12, 128'h13);
      send_a({64'hFFFF_0000_AAAA_5555, 64'h0123_4567_89AB_CDEF}, 128'h8000_0000,
             128'h5, {128{1'b1}});
      wait_drain();
      chk("b2b_phit_count", 128'(hs_log.size()), 128'd12);
      if (hs_log.size() == 12) chk("b2b_no_gap", 128'(hs_log[11] - hs_log[0]), 128'd11);
      @(negedge clk);
      chk1("idle_after_b2b", ifa.phit_valid_o, 1'b0);

      // Backpressure pattern 1,0,0,1
      bp_en = 1'b1;
      @(posedge clk);
      #1;
      send_a(128'hA0, 128'hA1, 128'hA2, 128'hA3);
      send_a(128'hB0, 128'hB1, 128'hB2, 128'hB3);
      wait_drain();
      bp_en = 1'b0;

      // 520-bit flit: 5 beats, last beat carries 8 bits, upper 120 zero
      @(posedge clk);
      #1;
      send_b(8'hA7, 128'h100, 128'h101, 128'h102, 128'h103, 128'h0000_00A7);
      wait_drain();

      // Single-beat configuration behaves as a register slice
      @(posedge clk);
      #1;
      send_c(64'hDEAD_BEEF_0123_4567, 128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567);
      send_c(64'h1, 128'h1);
      wait_drain();
      @(negedge clk);
      chk1("c_idle_after", ifc.phit_valid_o, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
